// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, command/state enums and address-split helpers for cache_ctrl
package cache_pkg;
  localparam int ADDR_W     = 19;
  localparam int TAG_W      = 10;
  localparam int SET_W      = 5;
  localparam int OFF_W      = 4;
  localparam int WAYS       = 2;
  localparam int BUS_W      = 16;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 3;
  localparam int SETS       = 1 << SET_W;
  localparam int LINE_W     = TAG_W + SET_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_READ8   = 3'd1,
    CMD_READ16  = 3'd2,
    CMD_WRITE8  = 3'd3,
    CMD_WRITE16 = 3'd4,
    CMD_INV     = 3'd5
  } cpu_cmd_e;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL,
    S_RESP
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: SET_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/cache_way_store.sv
// rtl/cache_way_store.sv - one cache way: tag/valid/dirty per set and a beat-addressed line data array
module cache_way_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [SET_W-1:0]  i_set,
  input  logic [BEAT_W-1:0] i_beat,
  input  logic [1:0]        i_be,
  input  logic [BUS_W-1:0]  i_wdata,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_set_dirty,
  input  logic              i_inval,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [BUS_W-1:0]  o_rdata
);
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [BUS_W-1:0] r_data [SETS*LINE_BEATS];
  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [SET_W+BEAT_W-1:0] w_idx;

  assign w_idx = {i_set, i_beat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_tag_we) begin
      r_valid[i_set] <= 1'b1;
      r_dirty[i_set] <= 1'b0;
    end else if (i_inval) begin
      r_valid[i_set] <= 1'b0;
      r_dirty[i_set] <= 1'b0;
    end else if (i_set_dirty) begin
      r_dirty[i_set] <= 1'b1;
    end
  end

  // Tags and data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[i_set] <= i_tag;
    if (i_be[0])  r_data[w_idx][7:0]  <= i_wdata[7:0];
    if (i_be[1])  r_data[w_idx][15:8] <= i_wdata[15:8];
  end

  assign o_tag   = r_tag[i_set];
  assign o_valid = r_valid[i_set];
  assign o_dirty = r_dirty[i_set];
  assign o_rdata = r_data[w_idx];
endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 2-way write-back write-allocate cache controller with 8-beat line bursts
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              R,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [2:0]        cpu_cmd,
  input  logic [BUS_W-1:0]  cpu_wdata,
  output logic [BUS_W-1:0]  cpu_rdata,
  output logic              cpu_ready,
  output logic [LINE_W-1:0] mem_addr,
  output logic [1:0]        mem_cmd,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_ack
);
  state_e            r_state, w_next;
  cpu_cmd_e          r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [BUS_W-1:0]  r_wdata;
  logic [SETS-1:0]   r_lru;
  logic              r_victim;
  logic [BEAT_W-1:0] r_beat;
  logic [BUS_W-1:0]  r_result;
  logic [BUS_W-1:0]  r_rdata;
  logic              r_ready;

  logic [TAG_W-1:0]  w_tag [WAYS];
  logic [BUS_W-1:0]  w_rdata [WAYS];
  logic [1:0]        w_be [WAYS];
  logic [WAYS-1:0]   w_valid, w_dirty, w_hit, w_tag_we, w_set_dirty, w_inval;
  logic [SET_W-1:0]  w_set;
  logic [TAG_W-1:0]  w_req_tag;
  logic [OFF_W-1:0]  w_off;
  logic [BEAT_W-1:0] w_beat_sel;
  logic [BUS_W-1:0]  w_wdata, w_word, w_rd_result;
  logic              w_any_hit, w_hit_way, w_miss_victim, w_is_write, w_accept;

  assign w_set      = addr_set(r_addr);
  assign w_req_tag  = addr_tag(r_addr);
  assign w_off      = addr_off(r_addr);
  assign w_beat_sel = (r_state == S_WB || r_state == S_FILL) ? r_beat : w_off[OFF_W-1:1];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hit[g] = w_valid[g] && (w_tag[g] == w_req_tag);
    cache_way_store u_way (
      .clk         (clk),
      .rst         (R),
      .i_set       (w_set),
      .i_beat      (w_beat_sel),
      .i_be        (w_be[g]),
      .i_wdata     (w_wdata),
      .i_tag_we    (w_tag_we[g]),
      .i_tag       (w_req_tag),
      .i_set_dirty (w_set_dirty[g]),
      .i_inval     (w_inval[g]),
      .o_tag       (w_tag[g]),
      .o_valid     (w_valid[g]),
      .o_dirty     (w_dirty[g]),
      .o_rdata     (w_rdata[g])
    );
  end

  assign w_any_hit     = |w_hit;
  assign w_hit_way     = w_hit[1];
  assign w_miss_victim = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_set]);
  assign w_word        = w_rdata[w_hit_way];
  assign w_is_write    = (r_cmd == CMD_WRITE8) || (r_cmd == CMD_WRITE16);
  assign w_accept      = !r_ready && (cpu_cmd >= 3'd1) && (cpu_cmd <= 3'd5);

  always_comb begin
    w_rd_result = '0;
    if (r_cmd == CMD_READ16)
      w_rd_result = w_word;
    else if (r_cmd == CMD_READ8)
      w_rd_result = {8'h00, w_off[0] ? w_word[15:8] : w_word[7:0]};
  end

  always_comb begin
    w_next      = r_state;
    w_tag_we    = '0;
    w_set_dirty = '0;
    w_inval     = '0;
    for (int i = 0; i < WAYS; i++) w_be[i] = 2'b00;
    w_wdata = (r_state == S_FILL) ? mem_rdata :
              (r_cmd == CMD_WRITE8) ? {r_wdata[7:0], r_wdata[7:0]} : r_wdata;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (r_cmd == CMD_INV) begin
          if (w_any_hit && w_dirty[w_hit_way]) begin
            w_next = S_WB;
          end else begin
            if (w_any_hit) w_inval[w_hit_way] = 1'b1;
            w_next = S_RESP;
          end
        end else if (w_any_hit) begin
          if (w_is_write) begin
            // Byte lane picked by addr[0]; 16-bit writes ignore it.
            w_be[w_hit_way]        = (r_cmd == CMD_WRITE16) ? 2'b11 : (w_off[0] ? 2'b10 : 2'b01);
            w_set_dirty[w_hit_way] = 1'b1;
          end
          w_next = S_RESP;
        end else begin
          w_next = (w_valid[w_miss_victim] && w_dirty[w_miss_victim]) ? S_WB : S_FILL_REQ;
        end
      end
      S_WB: if (r_beat == LAST_BEAT) w_next = S_WB_WAIT;
      S_WB_WAIT: begin
        if (mem_ack) begin
          if (r_cmd == CMD_INV) begin
            w_inval[r_victim] = 1'b1;
            w_next = S_RESP;
          end else begin
            w_next = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ: w_next = S_FILL;
      S_FILL: begin
        if (mem_ack) begin
          w_be[r_victim] = 2'b11;
          if (r_beat == LAST_BEAT) begin
            w_tag_we[r_victim] = 1'b1;
            w_next = S_LOOKUP;
          end
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_state  <= S_IDLE;
      r_cmd    <= CMD_NOP;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lru    <= '0;
      r_victim <= 1'b0;
      r_beat   <= '0;
      r_result <= '0;
      r_rdata  <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (r_state == S_RESP);
      r_rdata <= (r_state == S_RESP) ? r_result : '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd   <= cpu_cmd_e'(cpu_cmd);
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          r_victim <= w_any_hit ? w_hit_way : w_miss_victim;
          r_beat   <= '0;
          r_result <= w_rd_result;
          if (w_any_hit && r_cmd != CMD_INV) r_lru[w_set] <= ~w_hit_way;
        end
        S_WB:    r_beat <= r_beat + 1'b1;
        S_FILL:  if (mem_ack) r_beat <= r_beat + 1'b1;
        default: ;
      endcase
    end
  end

  assign cpu_ready = r_ready;
  assign cpu_rdata = r_rdata;
  assign mem_cmd   = (r_state == S_WB) ? MEM_WRITE : (r_state == S_FILL_REQ) ? MEM_READ : MEM_NOP;
  assign mem_addr  = (r_state == S_WB)       ? {w_tag[r_victim], w_set} :
                     (r_state == S_FILL_REQ) ? {w_req_tag, w_set} : '0;
  assign mem_wdata = (r_state == S_WB) ? w_rdata[r_victim] : '0;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with a burst memory model
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        R;
  logic [18:0] cpu_addr;
  logic [2:0]  cpu_cmd;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [14:0] mem_addr;
  logic [1:0]  mem_cmd;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] q_rsp [$];
  logic [16:0] q_mem [$];
  logic [15:0] mem_store [int];
  int fill_beat = -1;

  cache_ctrl dut (
    .clk       (clk),
    .R         (R),
    .cpu_addr  (cpu_addr),
    .cpu_cmd   (cpu_cmd),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_cmd   (mem_cmd),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Untouched lines hold byte n = n*0x11, with the high byte of each beat tagged by line-1.
  function automatic logic [15:0] mem_word(input int line, input int beat);
    logic [7:0] lo, hi, lx;
    if (mem_store.exists(line * 8 + beat)) return mem_store[line * 8 + beat];
    lo = 8'(2 * beat * 17);
    hi = 8'((2 * beat + 1) * 17);
    lx = 8'(line - 1);
    return {hi ^ lx, lo};
  endfunction

  task automatic exp_mem(input logic [1:0] cmd, input logic [14:0] addr);
    q_mem.push_back({cmd, addr});
  endtask

  task automatic pop_mem(input logic [1:0] cmd, input logic [14:0] addr);
    logic [16:0] e;
    if (q_mem.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_mem_traffic: got cmd=%0d addr=0x%0h expected none", cmd, addr);
    end else begin
      e = q_mem.pop_front();
      check("mem_cmd", 32'(cmd), 32'(e[16:15]));
      check("mem_addr", 32'(addr), 32'(e[14:0]));
    end
  endtask

  initial begin
    int line;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (R) continue;
      if (mem_cmd == 2'd2) begin
        pop_mem(mem_cmd, mem_addr);
        line = int'(mem_addr);
        mem_store[line * 8] = mem_wdata;
        for (int i = 1; i < 8; i++) begin
          @(posedge clk); #1;
          check("wb_cmd_held", 32'(mem_cmd), 32'd2);
          mem_store[line * 8 + i] = mem_wdata;
        end
        @(posedge clk); #1;
        check("wb_cmd_drop", 32'(mem_cmd), 32'd0);
        mem_ack = 1'b1;
      end else if (mem_cmd == 2'd1) begin
        pop_mem(mem_cmd, mem_addr);
        line = int'(mem_addr);
        @(posedge clk); #1;
        check("rd_cmd_one_cycle", 32'(mem_cmd), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8 && !R; i++) begin
          mem_rdata = mem_word(line, i);
          mem_ack   = 1'b1;
          fill_beat = i;
          @(posedge clk); #1;
        end
        mem_ack   = 1'b0;
        fill_beat = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (cpu_ready === 1'b1) begin
      if (q_rsp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got rdata=0x%0h expected no response", cpu_rdata);
      end else begin
        check("cpu_rdata", 32'(cpu_rdata), 32'(q_rsp.pop_front()));
      end
    end
  end

  task automatic req(input logic [2:0] cmd, input logic [18:0] addr, input logic [15:0] wd,
                     input logic [15:0] exp, input int exp_lat);
    int cyc = 0;
    q_rsp.push_back(exp);
    cpu_cmd   = cmd;
    cpu_addr  = addr;
    cpu_wdata = wd;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (cpu_ready !== 1'b1 && cyc < 300);
    cpu_cmd = 3'd0;
    if (cpu_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: cmd=%0d addr=0x%0h got no ready expected ready", cmd, addr);
    end else if (exp_lat >= 0) begin
      check("hit_latency", 32'(cyc - 1), 32'(exp_lat));
    end
    @(posedge clk); #1;
    check("ready_pulse_width", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    R = 1'b1;
    cpu_cmd = '0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mem_cmd", 32'(mem_cmd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    R = 1'b0;
    @(posedge clk); #1;

    exp_mem(2'd1, 15'h0001);
    req(3'd2, 19'h00010, 16'h0000, 16'h1100, -1);
    req(3'd1, 19'h00013, 16'h0000, 16'h0033, 2);
    req(3'd3, 19'h00013, 16'h00AB, 16'h0000, 2);
    req(3'd2, 19'h00012, 16'h0000, 16'hAB22, 2);

    exp_mem(2'd1, 15'h0021);
    req(3'd2, 19'h00210, 16'h0000, 16'h3100, -1);
    exp_mem(2'd2, 15'h0001);
    exp_mem(2'd1, 15'h0041);
    req(3'd2, 19'h00410, 16'h0000, 16'h5100, -1);
    check("evict_wb_beat0", 32'(mem_word(1, 0)), 32'h1100);
    check("evict_wb_beat1", 32'(mem_word(1, 1)), 32'hAB22);
    check("evict_wb_beat7", 32'(mem_word(1, 7)), 32'hFFEE);
    exp_mem(2'd1, 15'h0001);
    req(3'd2, 19'h00010, 16'h0000, 16'h1100, -1);
    req(3'd2, 19'h00012, 16'h0000, 16'hAB22, 2);

    req(3'd5, 19'h00210, 16'h0000, 16'h0000, 2);
    exp_mem(2'd1, 15'h0021);
    req(3'd2, 19'h00210, 16'h0000, 16'h3100, -1);
    req(3'd5, 19'h00210, 16'h0000, 16'h0000, 2);
    exp_mem(2'd1, 15'h0021);
    req(3'd2, 19'h00214, 16'h0000, 16'h7544, -1);

    req(3'd4, 19'h00017, 16'hBEEF, 16'h0000, 2);
    exp_mem(2'd2, 15'h0001);
    req(3'd5, 19'h00010, 16'h0000, 16'h0000, -1);
    check("inv_wb_beat3", 32'(mem_word(1, 3)), 32'hBEEF);
    check("inv_wb_beat1", 32'(mem_word(1, 1)), 32'hAB22);
    exp_mem(2'd1, 15'h0001);
    req(3'd2, 19'h00016, 16'h0000, 16'hBEEF, -1);

    exp_mem(2'd1, 15'h0081);
    cpu_cmd  = 3'd2;
    cpu_addr = 19'h00810;
    t = 0;
    while (fill_beat != 3 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    check("fill_beat3_reached", 32'(fill_beat), 32'd3);
    R = 1'b1;
    #1;
    check("midfill_mem_cmd", 32'(mem_cmd), 32'd0);
    check("midfill_cpu_ready", 32'(cpu_ready), 32'd0);
    check("midfill_cpu_rdata", 32'(cpu_rdata), 32'd0);
    cpu_cmd = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    R = 1'b0;
    @(posedge clk); #1;
    exp_mem(2'd1, 15'h0001);
    req(3'd2, 19'h00010, 16'h0000, 16'h1100, -1);

    repeat (5) @(posedge clk);
    #1;
    check("rsp_queue_empty", 32'(q_rsp.size()), 32'd0);
    check("mem_queue_empty", 32'(q_mem.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
